// File: rtl/rr_arbiter8_if.sv
// rtl/rr_arbiter8_if.sv - request/grant bundle between requesters and rr_arbiter8
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] grant_idx;
  logic       grant_en;
  logic       timeout_flag;

  // master: requester side; slave: arbiter side
  modport master (
    output req,
    output done,
    input  grant_idx,
    input  grant_en,
    input  timeout_flag
  );

  modport slave (
    input  req,
    input  done,
    output grant_idx,
    output grant_en,
    output timeout_flag
  );
endinterface

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - eight-way round-robin arbiter with hold timeout and one-cycle gap
module rr_arbiter8 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter8_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [2:0]  ptr, ptr_nx;
  logic [2:0]  idx, idx_nx;
  logic        en, en_nx;
  logic        flag, flag_nx;
  logic [15:0] cnt, cnt_nx;

  logic        win_vld;
  logic [2:0]  win_idx;
  logic        own_req;
  logic        to_hit;
  logic        rel;

  // Descending scan so the candidate closest to ptr is assigned last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr;
    for (int k = 7; k >= 0; k--) begin
      if (bus.req[ptr + 3'(k)]) begin
        win_vld = 1'b1;
        win_idx = ptr + 3'(k);
      end
    end
  end

  assign own_req = bus.req[idx];
  assign to_hit  = TO_EN && (cnt == TO_LAST);
  assign rel     = bus.done || !own_req || to_hit;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    idx_nx   = idx;
    en_nx    = en;
    flag_nx  = 1'b0;
    cnt_nx   = cnt;

    case (state)
      IDLE, GAP: begin
        if (win_vld) begin
          idx_nx   = win_idx;
          en_nx    = 1'b1;
          cnt_nx   = 16'd0;
          state_nx = GRANT;
        end else begin
          en_nx    = 1'b0;
          state_nx = IDLE;
        end
      end
      GRANT: begin
        // Saturate so a disabled timeout can never alias to a match.
        cnt_nx = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        if (rel) begin
          en_nx    = 1'b0;
          ptr_nx   = idx + 3'd1;
          flag_nx  = to_hit && !bus.done && own_req;
          state_nx = GAP;
        end
      end
      default: begin
        en_nx    = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd0;
      idx   <= 3'd0;
      en    <= 1'b0;
      flag  <= 1'b0;
      cnt   <= 16'd0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      idx   <= idx_nx;
      en    <= en_nx;
      flag  <= flag_nx;
      cnt   <= cnt_nx;
    end
  end

  assign bus.grant_idx    = idx;
  assign bus.grant_en     = en;
  assign bus.timeout_flag = flag;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed and randomized checks of rr_arbiter8 against a reference model
module tb_rr_arbiter8;

  localparam int TO = 16;

  logic clk;
  logic rst;
  rr_arbiter8_if bus ();

  rr_arbiter8 #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: 0 idle, 1 holding a grant, 2 gap
  int m_phase;
  int m_ptr;
  int m_idx;
  int m_en;
  int m_flag;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_idx   = 0;
    m_en    = 0;
    m_flag  = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    int w;
    bit by_done, by_drop, by_to;
    m_flag = 0;
    if (m_phase == 1) begin
      by_done = d;
      by_drop = !r[m_idx];
      by_to   = (TO != 0) && (m_cnt == TO - 1);
      m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (by_done || by_drop || by_to) begin
        m_en    = 0;
        m_ptr   = (m_idx + 1) % 8;
        m_phase = 2;
        m_flag  = (by_to && !by_done && !by_drop) ? 1 : 0;
      end
    end else begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_idx   = w;
        m_en    = 1;
        m_cnt   = 0;
        m_phase = 1;
      end else begin
        m_en    = 0;
        m_phase = 0;
      end
    end
  endtask

  task automatic cycle();
    model_step(bus.req, bus.done);
    @(posedge clk);
    #1;
    chk("grant_en", 32'(bus.grant_en), 32'(m_en));
    chk("grant_idx", 32'(bus.grant_idx), 32'(m_idx));
    chk("timeout_flag", 32'(bus.timeout_flag), 32'(m_flag));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  int hi;

  initial begin
    rst      = 1'b1;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(bus.grant_en), 32'd0);
    chk("rst_idx", 32'(bus.grant_idx), 32'd0);
    chk("rst_flag", 32'(bus.timeout_flag), 32'd0);
    chk("rst_ptr", 32'(dut.ptr), 32'd0);
    rst = 1'b0;

    // single requester, done on third grant cycle, regrant after gap
    bus.req = 8'b0000_0100;
    cycle();
    chk("single_en", 32'(bus.grant_en), 32'd1);
    chk("single_idx", 32'(bus.grant_idx), 32'd2);
    cycle();
    cycle();
    bus.done = 1'b1;
    cycle();
    bus.done = 1'b0;
    chk("single_rel_en", 32'(bus.grant_en), 32'd0);
    chk("single_ptr", 32'(dut.ptr), 32'd3);
    cycle();
    chk("single_regrant_en", 32'(bus.grant_en), 32'd1);
    chk("single_regrant_idx", 32'(bus.grant_idx), 32'd2);
    bus.req = 8'h00;
    cycle();
    cycle();

    // full fairness from ptr 0
    do_reset();
    bus.req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk("fair_en", 32'(bus.grant_en), 32'd1);
      chk("fair_idx", 32'(bus.grant_idx), 32'(i % 8));
      bus.done = 1'b1;
      cycle();
      bus.done = 1'b0;
      chk("fair_gap", 32'(bus.grant_en), 32'd0);
    end
    bus.req = 8'h00;
    cycle();

    // wrap-around: release 6, then 7 before 0
    bus.req = 8'h40;
    cycle();
    chk("wrap_g6", 32'(bus.grant_idx), 32'd6);
    bus.done = 1'b1;
    cycle();
    bus.done = 1'b0;
    chk("wrap_ptr", 32'(dut.ptr), 32'd7);
    bus.req = 8'b1000_0001;
    cycle();
    chk("wrap_g7", 32'(bus.grant_idx), 32'd7);
    bus.done = 1'b1;
    cycle();
    bus.done = 1'b0;
    cycle();
    chk("wrap_g0_en", 32'(bus.grant_en), 32'd1);
    chk("wrap_g0", 32'(bus.grant_idx), 32'd0);
    bus.req = 8'h00;
    cycle();
    cycle();

    // timeout: stuck grant lasts TO cycles, flag coincides with first low cycle
    bus.req = 8'b0010_0000;
    cycle();
    hi = 0;
    while (bus.grant_en && hi < 40) begin
      hi++;
      cycle();
    end
    chk("to_len", 32'(hi), 32'(TO));
    chk("to_flag", 32'(bus.timeout_flag), 32'd1);
    cycle();
    chk("to_flag_clr", 32'(bus.timeout_flag), 32'd0);
    chk("to_regrant", 32'(bus.grant_idx), 32'd5);
    repeat (TO - 1) cycle();
    bus.done = 1'b1;
    cycle();
    bus.done = 1'b0;
    chk("to_done_en", 32'(bus.grant_en), 32'd0);
    chk("to_done_flag", 32'(bus.timeout_flag), 32'd0);
    bus.req = 8'h00;
    cycle();
    cycle();

    // owner drop: 3 held with req 0A, dropping bit 3 hands over to 1
    bus.req = 8'b0000_0100;
    cycle();
    bus.done = 1'b1;
    cycle();
    bus.done = 1'b0;
    bus.req  = 8'b0000_1010;
    cycle();
    chk("drop_g3", 32'(bus.grant_idx), 32'd3);
    bus.req = 8'b0000_0010;
    cycle();
    chk("drop_en", 32'(bus.grant_en), 32'd0);
    chk("drop_flag", 32'(bus.timeout_flag), 32'd0);
    cycle();
    chk("drop_g1_en", 32'(bus.grant_en), 32'd1);
    chk("drop_g1", 32'(bus.grant_idx), 32'd1);
    bus.req = 8'h00;
    cycle();
    cycle();

    // randomized traffic, requests change occasionally so timeouts still occur
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) bus.req = 8'($urandom);
      bus.done = ($urandom_range(5) == 0);
      cycle();
    end
    bus.done = 1'b0;

    // async reset while 5 is granted
    bus.req = 8'b0010_0000;
    cycle();
    cycle();
    cycle();
    chk("ar_pre_en", 32'(bus.grant_en), 32'd1);
    chk("ar_pre_idx", 32'(bus.grant_idx), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_en", 32'(bus.grant_en), 32'd0);
    chk("ar_idx", 32'(bus.grant_idx), 32'd0);
    chk("ar_ptr", 32'(dut.ptr), 32'd0);
    bus.req = 8'hFF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle();
    chk("ar_first_en", 32'(bus.grant_en), 32'd1);
    chk("ar_first_idx", 32'(bus.grant_idx), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
